seq_csk_multiplier: RTL and testbench

//  Iterative unsigned shift-add multiplier for the ALU32 multiply path.

---
 rtl/seq_csk_multiplier_pkg.sv | 13 +
 rtl/seq_csk_multiplier_csk_adder_n.sv | 38 +++
 rtl/seq_csk_multiplier.sv | 148 ++++++++++++++
 tb/tb_seq_csk_multiplier.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_csk_multiplier_pkg.sv
// Shared types and constants for the iterative carry-skip multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MUL_WIDTH = 32;
  localparam int CSK_BLK   = 4;

endpackage : mul_pkg

// File: rtl/seq_csk_multiplier_csk_adder_n.sv
// WIDTH-bit carry-skip adder: a chain of 4-bit ripple blocks, where a block
// whose bits all propagate passes its carry-in straight to its carry-out.
module csk_adder_n
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / CSK_BLK;

  logic [NB:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [CSK_BLK-1:0] a_s;
    logic [CSK_BLK-1:0] b_s;
    logic [CSK_BLK-1:0] p_s;
    logic [CSK_BLK:0]   rip_s;

    assign a_s   = a[g*CSK_BLK +: CSK_BLK];
    assign b_s   = b[g*CSK_BLK +: CSK_BLK];
    assign p_s   = a_s ^ b_s;
    assign rip_s = {1'b0, a_s} + {1'b0, b_s} + {{CSK_BLK{1'b0}}, carry_s[g]};
    assign sum[g*CSK_BLK +: CSK_BLK] = rip_s[CSK_BLK-1:0];
    // Full propagate means the ripple carry equals cin, so skip the block.
    assign carry_s[g+1] = (&p_s) ? carry_s[g] : rip_s[CSK_BLK];
  end

  assign cout = carry_s[NB];

endmodule : csk_adder_n

// File: rtl/seq_csk_multiplier.sv
// Iterative unsigned shift-add multiplier: one carry-skip add and one right
// shift per cycle, WIDTH cycles per product, zero operands short-circuited.
module seq_csk_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  if ((WIDTH % CSK_BLK) != 0 || WIDTH < CSK_BLK) begin : g_width_check
    $error("seq_csk_multiplier: WIDTH must be a multiple of 4 and >= 4");
  end

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q,     state_d;
  logic [WIDTH-1:0]     mcand_q,     mcand_d;
  logic [WIDTH-1:0]     acc_q,       acc_d;
  logic [WIDTH-1:0]     mq_q,        mq_d;
  logic [CW-1:0]        count_q,     count_d;
  logic [2*WIDTH-1:0]   product_q,   product_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q,      busy_d;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;
  logic [2*WIDTH-1:0]   shift_s;

  assign addend_s = mq_q[0] ? mcand_q : {WIDTH{1'b0}};
  // The carry-out becomes the new acc MSB, so no bit of the sum is lost.
  assign shift_s  = {cout_s, sum_s, mq_q[WIDTH-1:1]};

  csk_adder_n #(
    .WIDTH(WIDTH)
  ) u_csk (
    .a   (acc_q),
    .b   (addend_s),
    .cin (1'b0),
    .sum (sum_s),
    .cout(cout_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      mq_q        <= {WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      product_q   <= {(2*WIDTH){1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mcand_d = a;
          acc_d   = {WIDTH{1'b0}};
          mq_d    = b;
          busy_d  = 1'b1;
          if (a == {WIDTH{1'b0}} || b == {WIDTH{1'b0}}) begin
            product_d   = {(2*WIDTH){1'b0}};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            count_d = {CW{1'b0}};
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = shift_s[2*WIDTH-1:WIDTH];
        mq_d  = shift_s[WIDTH-1:0];
        if (count_q == LAST) begin
          // Hold the counter on the final step so it never wraps.
          count_d     = count_q;
          product_d   = shift_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = out_valid_q;
    busy      = busy_q;
    product   = product_q;
    if (!rst && state_q == IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

endmodule : seq_csk_multiplier

// File: tb/tb_seq_csk_multiplier.sv
// Self-checking bench for seq_csk_multiplier: directed table, randomized ops
// against a plain-arithmetic model, back-pressure, ignored input and reset abort.
module tb_seq_csk_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int tests;
  int fails;

  seq_csk_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
    int             exp_lat;
    int             hold;
    bit             noise;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: exact product by plain 64-bit arithmetic; latency in edges after accept.
  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned px;
    longint unsigned py;
    px = longint'(x);
    py = longint'(y);
    return px * py;
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x == '0 || y == '0) ? 0 : W;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p, input int exp_lat,
                        input int hold, input bit noise, input string nm);
    int guard;
    int lat;
    int busy_n;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({nm, " in_ready before accept"}, 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_n = 0;
    if (hold == 0) out_ready = 1'b1;
    while (!out_valid && lat < W + 8) begin
      if (busy) busy_n++;
      if (noise && lat == 5) begin
        check({nm, " in_ready during run"}, 64'(in_ready), 64'd0);
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " product"}, product, exp_p);
    for (int h = 0; h < hold; h++) begin
      if (busy) busy_n++;
      if (product !== exp_p || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        check({nm, " stall {product,in_ready,out_valid}"}, {product[61:0], in_ready, out_valid},
              {exp_p[61:0], 1'b0, 1'b1});
      end else begin
        tests++;
      end
      @(posedge clk); #1;
    end
    if (hold != 0) busy_n -= hold;
    if (busy) busy_n++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " busy cycles"}, 64'(busy_n), 64'(exp_lat + 1));
    check({nm, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({nm, " busy after handshake"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, W, 0,  1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, W, 0,  1'b0};
    vecs[2] = '{32'h1234_5678,  32'd0,          64'd0,                   0, 0,  1'b0};
    vecs[3] = '{32'd7,          32'd9,          64'd63,                  W, 10, 1'b0};
    vecs[4] = '{32'd100,        32'd200,        64'd20000,               W, 0,  1'b1};
    vecs[5] = '{32'd0,          32'hFFFF_FFFF,  64'd0,                   0, 3,  1'b0};
    vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, W, 0,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", product, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_lat,
             vecs[i].hold, vecs[i].noise, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 6)
        0: ra = '0;
        1: rb = rb & 32'h0000_00FF;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ra, rb, model_p(ra, rb), model_lat(ra, rb),
             (i % 5 == 0) ? 2 : 0, (i % 4 == 1), $sformatf("rnd%0d", i));
    end

    // Abort an operation with reset ten cycles into RUN.
    a = 32'h0000_DEAD;
    b = 32'h0000_BEEF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort product", product, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort in_ready during rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    run_op(32'd2, 32'd3, 64'd6, W, 0, 1'b0, "after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_csk_multiplier
